addsub_chunked: RTL and testbench

ADDSUB_CHUNKED -- requirements
Module: addsub_chunked

---
 rtl/addsub_chunked.sv | 242 ++++++++++++++++++++++++
 tb/tb_addsub_chunked.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/addsub_chunked.sv
`default_nettype none
// ============================================================================
// Module      : addsub_chunked
// Description : Multi-cycle adder/subtractor that processes WIDTH-bit operands
//               CHUNK bits per clock. A request is accepted in IDLE, ripples
//               through NCH = WIDTH/CHUNK chunks in RUN (one chunk per cycle,
//               carry/borrow registered between chunks), then presents the
//               result in DONE until the consumer takes it.
//
// Ports       : clk        - single clock, rising-edge active
//               rst_n      - synchronous active-low reset
//               in_valid   - request valid
//               in_ready   - block idle and able to accept a request
//               a, b       - WIDTH-bit operands
//               mode       - 0 = add, 1 = subtract
//               cin        - carry-in (add) / borrow-in (subtract)
//               out_valid  - result valid
//               out_ready  - consumer accepts result
//               result     - WIDTH-bit sum or difference
//               cout       - carry-out (add) / borrow-out (subtract)
//               ovf        - signed two's-complement overflow
//
// Revision    : 1.0 - initial release
// ============================================================================
module addsub_chunked #(
    parameter int WIDTH = 32,
    parameter int CHUNK = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             mode,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             cout,
    output logic             ovf
);

    // ------------------------------------------------------------------------
    // Derived constants
    // ------------------------------------------------------------------------
    localparam int NCH = WIDTH / CHUNK;
    // Chunk index width; at least one bit so NCH == 1 still has a legal vector.
    localparam int KW  = (NCH > 1) ? $clog2(NCH) : 1;
    localparam logic [KW-1:0] C_K_LAST = KW'(NCH - 1);

    // Elaboration guard: the chunk walk only covers the word exactly when
    // WIDTH is a whole number of chunks.
    generate
        if ((CHUNK < 1) || ((WIDTH % CHUNK) != 0)) begin : g_bad_params
            $error("addsub_chunked: WIDTH must be a positive multiple of CHUNK");
        end
    endgenerate

    // ------------------------------------------------------------------------
    // State machine encoding
    // ------------------------------------------------------------------------
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    // ------------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------------
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic             r_mode;
    logic             r_carry;      // carry (add) or borrow (sub) into chunk k
    logic [KW-1:0]    r_k;          // index of the chunk processed next
    logic [WIDTH-1:0] r_result;
    logic             r_cout;
    logic             r_ovf;

    // ------------------------------------------------------------------------
    // Combinational signals
    // ------------------------------------------------------------------------
    logic             w_accept;
    logic             w_last;
    logic [CHUNK-1:0] w_a_ch;
    logic [CHUNK-1:0] w_b_ch;
    logic [CHUNK:0]   w_add_full;
    logic [CHUNK:0]   w_sub_full;
    logic [CHUNK-1:0] w_sum_ch;
    logic             w_carry_ch;
    logic [WIDTH-1:0] w_result_nxt;
    logic             w_a_msb;
    logic             w_b_msb;
    logic             w_r_msb;
    logic             w_ovf_fin;

    // ------------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------------
    // FSM: next state and handshake outputs
    // in_ready is qualified by rst_n so a request is never advertised while
    // reset is being held, even though the state register already reads IDLE.
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        in_ready    = 1'b0;
        out_valid   = 1'b0;
        case (r_state)
            S_IDLE: begin
                in_ready = rst_n;
                if (in_valid) begin
                    w_state_nxt = S_RUN;
                end
            end
            S_RUN: begin
                if (w_last) begin
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    assign w_accept = in_valid && in_ready;
    assign w_last   = (r_k == C_K_LAST);

    // ------------------------------------------------------------------------
    // Chunk select: pick bits k*CHUNK +: CHUNK of the latched operands.
    // ------------------------------------------------------------------------
    always_comb begin
        w_a_ch = '0;
        w_b_ch = '0;
        for (int i = 0; i < NCH; i++) begin
            if (r_k == KW'(i)) begin
                w_a_ch = r_a[i*CHUNK +: CHUNK];
                w_b_ch = r_b[i*CHUNK +: CHUNK];
            end
        end
    end

    // ------------------------------------------------------------------------
    // One CHUNK-bit ripple stage. Both forms are computed one bit wider than
    // the chunk so the top bit is the outgoing carry (add) or borrow (sub):
    // a negative difference shows up as a set MSB in CHUNK+1 bits.
    // ------------------------------------------------------------------------
    assign w_add_full = {1'b0, w_a_ch} + {1'b0, w_b_ch} + {{CHUNK{1'b0}}, r_carry};
    assign w_sub_full = {1'b0, w_a_ch} - {1'b0, w_b_ch} - {{CHUNK{1'b0}}, r_carry};

    assign w_sum_ch   = r_mode ? w_sub_full[CHUNK-1:0] : w_add_full[CHUNK-1:0];
    assign w_carry_ch = r_mode ? w_sub_full[CHUNK]     : w_add_full[CHUNK];

    // Merge the new chunk into its slice of the result, leaving the others.
    always_comb begin
        w_result_nxt = r_result;
        for (int i = 0; i < NCH; i++) begin
            if (r_k == KW'(i)) begin
                w_result_nxt[i*CHUNK +: CHUNK] = w_sum_ch;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Signed overflow, evaluated while the last chunk is processed: the top
    // bit of that chunk is the result MSB.
    // add: operands share a sign and the result sign differs.
    // sub: operands differ in sign and the result sign differs from a.
    // ------------------------------------------------------------------------
    assign w_a_msb   = r_a[WIDTH-1];
    assign w_b_msb   = r_b[WIDTH-1];
    assign w_r_msb   = w_sum_ch[CHUNK-1];
    assign w_ovf_fin = r_mode ? ((w_a_msb ^ w_b_msb) & (w_r_msb ^ w_a_msb))
                              : (~(w_a_msb ^ w_b_msb) & (w_r_msb ^ w_a_msb));

    // ------------------------------------------------------------------------
    // Datapath registers
    // Operands are only captured on accept, so anything driven on the inputs
    // during RUN/DONE has no effect. Result/flags only change in RUN, so they
    // hold through DONE backpressure and stay put back in IDLE.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_a      <= '0;
            r_b      <= '0;
            r_mode   <= 1'b0;
            r_carry  <= 1'b0;
            r_k      <= '0;
            r_result <= '0;
            r_cout   <= 1'b0;
            r_ovf    <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_a     <= a;
                        r_b     <= b;
                        r_mode  <= mode;
                        r_carry <= cin;
                        r_k     <= '0;
                    end
                end
                S_RUN: begin
                    r_result <= w_result_nxt;
                    r_carry  <= w_carry_ch;
                    r_k      <= r_k + 1'b1;
                    if (w_last) begin
                        r_cout <= w_carry_ch;
                        r_ovf  <= w_ovf_fin;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign result = r_result;
    assign cout   = r_cout;
    assign ovf    = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_addsub_chunked.sv
`default_nettype none
// ============================================================================
// Module      : tb_addsub_chunked
// Description : Self-checking bench for addsub_chunked. Four instances
//               (CHUNK = 8, 1, 4, 32 at WIDTH = 32) each run directed cases,
//               a backpressure case, a reset-mid-RUN abort and a random
//               regression. Expected responses are queued on accept and a
//               per-instance monitor compares them when results are taken.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_addsub_chunked;

    localparam int W = 32;

    logic clk;
    int   n_pass;
    int   n_total;

    initial begin
        clk     = 1'b0;
        n_pass  = 0;
        n_total = 0;
    end
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    // Reference: plain WIDTH-bit arithmetic, packed as {cout, ovf, result}.
    function automatic logic [33:0] model(input logic [31:0] x, input logic [31:0] y,
                                          input logic m, input logic c);
        logic [32:0] s;
        logic [31:0] r;
        logic        co;
        logic        ov;
        if (!m) begin
            s  = {1'b0, x} + {1'b0, y} + 33'(c);
            r  = s[31:0];
            co = s[32];
            ov = (x[31] == y[31]) && (r[31] != x[31]);
        end else begin
            r  = x - y - 32'(c);
            co = ({1'b0, x} < ({1'b0, y} + 33'(c)));
            ov = (x[31] != y[31]) && (r[31] != x[31]);
        end
        return {co, ov, r};
    endfunction

    for (genvar gi = 0; gi < 4; gi++) begin : g_cfg
        localparam int CH   = (gi == 0) ? 8 : (gi == 1) ? 1 : (gi == 2) ? 4 : 32;
        localparam int NCH  = W / CH;
        localparam int NRST = (NCH >= 3) ? 3 : NCH;
        localparam int NOPS = (CH == 1) ? 700 : 1500;

        logic          rst_n;
        logic          in_valid;
        logic          in_ready;
        logic [W-1:0]  a;
        logic [W-1:0]  b;
        logic          mode;
        logic          cin;
        logic          out_valid;
        logic          out_ready;
        logic [W-1:0]  result;
        logic          cout;
        logic          ovf;
        int            orm;        // 0: out_ready high, 1: low, 2: random
        bit            done;
        logic [33:0]   sbq[$];
        logic [33:0]   m_exp;

        addsub_chunked #(.WIDTH(W), .CHUNK(CH)) u_dut (
            .clk       (clk),
            .rst_n     (rst_n),
            .in_valid  (in_valid),
            .in_ready  (in_ready),
            .a         (a),
            .b         (b),
            .mode      (mode),
            .cin       (cin),
            .out_valid (out_valid),
            .out_ready (out_ready),
            .result    (result),
            .cout      (cout),
            .ovf       (ovf)
        );

        always @(posedge clk) begin
            #2;
            case (orm)
                0:       out_ready = 1'b1;
                1:       out_ready = 1'b0;
                default: out_ready = ($urandom_range(0, 3) != 0);
            endcase
        end

        // Monitor: every taken result must match the oldest queued expectation.
        always @(negedge clk) begin
            if (rst_n === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1) begin
                chk($sformatf("c%0d_sb_nonempty", CH), 64'(sbq.size() != 0), 64'd1);
                if (sbq.size() != 0) begin
                    m_exp = sbq.pop_front();
                    chk($sformatf("c%0d_out{cout,ovf,result}", CH), 64'({cout, ovf, result}), 64'(m_exp));
                end
            end
        end

        task automatic junk();
            in_valid = 1'($urandom_range(0, 1));
            a        = $urandom;
            b        = $urandom;
            mode     = 1'($urandom_range(0, 1));
            cin      = 1'($urandom_range(0, 1));
        endtask

        // Called at posedge+1; returns at posedge+1 just after the accept edge.
        task automatic do_accept(input logic [31:0] ta, input logic [31:0] tb, input logic tm,
                                 input logic tc, input logic [33:0] exp, input bit push);
            int n;
            n = 0;
            while (!in_ready && n < 100) begin
                @(posedge clk); #1; n++;
            end
            chk($sformatf("c%0d_ready_before_accept", CH), 64'(in_ready), 64'd1);
            a = ta; b = tb; mode = tm; cin = tc; in_valid = 1'b1;
            @(posedge clk);
            if (push) sbq.push_back(exp);
            #1;
            junk();
        endtask

        task automatic do_latency();
            int lat;
            lat = 0;
            while (!out_valid && lat < NCH + 8) begin
                @(posedge clk); #1; lat++;
                junk();
            end
            chk($sformatf("c%0d_latency", CH), 64'(lat), 64'(NCH));
        endtask

        task automatic do_drain();
            int n;
            n = 0;
            while (!in_ready && n < 200) begin
                junk();
                @(posedge clk); #1; n++;
            end
            in_valid = 1'b0;
            chk($sformatf("c%0d_back_to_idle", CH), 64'(in_ready), 64'd1);
        endtask

        task automatic run_op(input logic [31:0] ta, input logic [31:0] tb, input logic tm,
                              input logic tc, input logic [33:0] exp);
            do_accept(ta, tb, tm, tc, exp, 1'b1);
            do_latency();
            do_drain();
        endtask

        function automatic logic [31:0] pick();
            case ($urandom_range(0, 11))
                0:       return 32'h0000_0000;
                1:       return 32'hFFFF_FFFF;
                2:       return 32'h8000_0000;
                3:       return 32'h7FFF_FFFF;
                default: return $urandom;
            endcase
        endfunction

        initial begin
            logic [31:0] ra;
            logic [31:0] rb;
            logic        rm;
            logic        rc;
            done     = 1'b0;
            orm      = 0;
            rst_n    = 1'b0;
            in_valid = 1'b0;
            a = '0; b = '0; mode = 1'b0; cin = 1'b0;

            repeat (3) @(posedge clk);
            @(negedge clk);
            chk($sformatf("c%0d_rst_in_ready", CH), 64'(in_ready), 64'd0);
            chk($sformatf("c%0d_rst_out_valid", CH), 64'(out_valid), 64'd0);
            chk($sformatf("c%0d_rst_outputs", CH), 64'({cout, ovf, result}), 64'd0);
            @(posedge clk); #1;
            rst_n = 1'b1;
            @(posedge clk); #1;
            chk($sformatf("c%0d_ready_after_rst", CH), 64'(in_ready), 64'd1);

            // Directed arithmetic corner cases with hand-derived answers.
            run_op(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, {1'b1, 1'b0, 32'h0000_0000});
            run_op(32'h0000_0000, 32'h0000_0001, 1'b1, 1'b0, {1'b1, 1'b0, 32'hFFFF_FFFF});
            run_op(32'h8000_0000, 32'h0000_0001, 1'b1, 1'b0, {1'b0, 1'b1, 32'h7FFF_FFFF});
            run_op(32'h0000_0100, 32'h0000_00FF, 1'b1, 1'b1, {1'b0, 1'b0, 32'h0000_0000});
            run_op(32'h7FFF_FFFF, 32'h0000_0000, 1'b0, 1'b1, {1'b0, 1'b1, 32'h8000_0000});

            // Backpressure: hold DONE for 5 cycles while hammering the inputs.
            orm = 1;
            do_accept(32'h1234_5678, 32'h0F0F_0F0F, 1'b0, 1'b0, {1'b0, 1'b0, 32'h2143_6587}, 1'b1);
            do_latency();
            for (int i = 0; i < 5; i++) begin
                junk();
                in_valid = 1'b1;
                @(posedge clk); #1;
                chk($sformatf("c%0d_bp_hold{valid,ready,result}", CH),
                    64'({out_valid, in_ready, result}), 64'({1'b1, 1'b0, 32'h2143_6587}));
            end
            in_valid = 1'b0;
            orm      = 0;
            @(posedge clk); #1;
            chk($sformatf("c%0d_bp_release{ready,valid}", CH), 64'({in_ready, out_valid}), 64'(2'b10));
            chk($sformatf("c%0d_idle_hold", CH), 64'({cout, ovf, result}), 64'({1'b0, 1'b0, 32'h2143_6587}));

            // Reset in the middle of RUN: operation dropped, outputs cleared.
            do_accept(32'hDEAD_BEEF, 32'h1111_1111, 1'b1, 1'b1, '0, 1'b0);
            for (int i = 1; i < NRST; i++) begin
                @(posedge clk); #1;
            end
            rst_n = 1'b0;
            in_valid = 1'b1;
            for (int i = 0; i < 3; i++) begin
                @(posedge clk); #1;
                chk($sformatf("c%0d_abort{valid,ready,cout,ovf,result}", CH),
                    64'({out_valid, in_ready, cout, ovf, result}), 64'd0);
            end
            in_valid = 1'b0;
            rst_n    = 1'b1;
            @(posedge clk); #1;
            chk($sformatf("c%0d_ready_after_abort", CH), 64'(in_ready), 64'd1);
            run_op(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, {1'b1, 1'b0, 32'h0000_0000});

            // Random regression with random consumer stalls.
            orm = 2;
            for (int n = 0; n < NOPS; n++) begin
                ra = pick();
                rb = pick();
                rm = 1'($urandom_range(0, 1));
                rc = 1'($urandom_range(0, 1));
                run_op(ra, rb, rm, rc, model(ra, rb, rm, rc));
                repeat ($urandom_range(0, 2)) begin
                    @(posedge clk); #1;
                end
            end
            orm = 0;
            repeat (4) @(posedge clk);
            #1;
            chk($sformatf("c%0d_sb_empty", CH), 64'(sbq.size()), 64'd0);
            done = 1'b1;
        end
    end

    initial begin
        int cyc;
        cyc = 0;
        while (!(g_cfg[0].done && g_cfg[1].done && g_cfg[2].done && g_cfg[3].done) && cyc < 90000) begin
            @(posedge clk);
            cyc++;
        end
        chk("all_configs_finished", 64'({g_cfg[0].done, g_cfg[1].done, g_cfg[2].done, g_cfg[3].done}), 64'(4'b1111));
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
